// File: rtl/hazard_ctrl.sv
// Hazard and flush control for the five-stage pipeline: load-use and
// mult/div interlocks, branch/jump squash, saturating event counters.
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             id_redirect,
  input  logic             id_md_op,
  input  logic             id_hilo_read,
  output logic             pc_write,
  output logic             pc_sel_redirect,
  output logic             ifid_hold,
  output logic             if_flush,
  output logic             idex_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned CW =
    (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MD_LAT - 1);

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic rs_hit, rt_hit;
  logic load_use, md_hazard, stall;
  logic issue, redirect;

  assign rs_hit    = (ex_rt == id_rs);
  assign rt_hit    = id_uses_rt & (ex_rt == id_rt);
  assign load_use  = ex_mem_read & (ex_rt != 5'd0)
                   & (rs_hit | rt_hit);
  assign md_busy   = (state_q == MD_BUSY);
  assign md_hazard = md_busy & (id_md_op | id_hilo_read);
  assign stall     = load_use | md_hazard;
  assign issue     = id_md_op & ~stall & ~rst;
  assign redirect  = id_redirect & ~stall & ~rst;

  // Busy window is MD_LAT cycles: cnt runs MD_LAT-1 down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (issue) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall && !rst && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (redirect && !(&flush_q)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    pc_write        = 1'b1;
    pc_sel_redirect = 1'b0;
    ifid_hold       = 1'b0;
    if_flush        = 1'b0;
    idex_bubble     = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_hold   = 1'b1;
      if_flush    = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      // Branch stays in ID and is re-evaluated once the stall clears.
      pc_write    = 1'b0;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else if (id_redirect) begin
      pc_sel_redirect = 1'b1;
      ifid_hold       = 1'b1;
      if_flush        = 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (MD_LAT 4/8) checked
// every cycle against a cycle-window model plus literal pins.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, id_redirect;
  logic       id_md_op, id_hilo_read;

  logic       pcw[2], psel[2], hold[2], flu[2], bub[2], busy[2];
  logic [3:0]  sc0, fc0;
  logic [15:0] sc1, fc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_redirect(id_redirect), .id_md_op(id_md_op),
    .id_hilo_read(id_hilo_read),
    .pc_write(pcw[0]), .pc_sel_redirect(psel[0]),
    .ifid_hold(hold[0]), .if_flush(flu[0]),
    .idex_bubble(bub[0]), .md_busy(busy[0]),
    .stall_cycles(sc0), .flush_count(fc0)
  );

  hazard_ctrl #(.MD_LAT(8), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_redirect(id_redirect), .id_md_op(id_md_op),
    .id_hilo_read(id_hilo_read),
    .pc_write(pcw[1]), .pc_sel_redirect(psel[1]),
    .ifid_hold(hold[1]), .if_flush(flu[1]),
    .idex_bubble(bub[1]), .md_busy(busy[1]),
    .stall_cycles(sc1), .flush_count(fc1)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: busy is a window of cycle numbers, counters are plain ints.
  int lat[2]  = '{4, 8};
  int cmax[2] = '{15, 65535};
  int cyc = 0;
  int bfrom[2], bto[2], msc[2], mfc[2];
  bit armed = 0;

  function automatic bit m_busy(int i);
    return (cyc >= bfrom[i]) && (cyc <= bto[i]);
  endfunction

  function automatic bit m_stall(int i);
    bit lu;
    lu = ex_mem_read && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
    return lu || (m_busy(i) && (id_md_op || id_hilo_read));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        bfrom[i] = 0;
        bto[i]   = -1;
        msc[i]   = 0;
        mfc[i]   = 0;
      end else if (armed) begin
        if (m_stall(i)) begin
          if (msc[i] < cmax[i]) msc[i] = msc[i] + 1;
        end else begin
          if (id_redirect && mfc[i] < cmax[i]) mfc[i] = mfc[i] + 1;
          if (id_md_op) begin
            bfrom[i] = cyc + 1;
            bto[i]   = cyc + lat[i];
          end
        end
      end
    end
    if (rst) armed = 1;
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        bit st, ep, es, eh, ef, eb;
        st = m_stall(i);
        ep = 1; es = 0; eh = 0; ef = 0; eb = 0;
        if (rst) begin
          ep = 0; eh = 1; ef = 1; eb = 1;
        end else if (st) begin
          ep = 0; eh = 1; eb = 1;
        end else if (id_redirect) begin
          es = 1; eh = 1; ef = 1;
        end
        chk($sformatf("d%0d_pc_write", i), 32'(pcw[i]), 32'(ep));
        chk($sformatf("d%0d_pc_sel", i), 32'(psel[i]), 32'(es));
        chk($sformatf("d%0d_ifid_hold", i), 32'(hold[i]), 32'(eh));
        chk($sformatf("d%0d_if_flush", i), 32'(flu[i]), 32'(ef));
        chk($sformatf("d%0d_bubble", i), 32'(bub[i]), 32'(eb));
        chk($sformatf("d%0d_md_busy", i), 32'(busy[i]),
            32'(m_busy(i)));
      end
      chk("d0_stall_cnt", 32'(sc0), 32'(msc[0]));
      chk("d0_flush_cnt", 32'(fc0), 32'(mfc[0]));
      chk("d1_stall_cnt", 32'(sc1), 32'(msc[1]));
      chk("d1_flush_cnt", 32'(fc1), 32'(mfc[1]));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 0; id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rt = 0; ex_mem_read = 0; id_redirect = 0;
    id_md_op = 0; id_hilo_read = 0;
  endtask

  task automatic do_reset();
    nxt();
    clr();
    rst = 1;
    nxt();
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr();
    rst = 1;
    @(negedge clk);
    chk("rst_pc_write", 32'(pcw[0]), 0);
    chk("rst_ifid_hold", 32'(hold[0]), 1);
    chk("rst_if_flush", 32'(flu[0]), 1);
    chk("rst_bubble", 32'(bub[0]), 1);
    nxt();
    clr();
    // idle flow
    for (int k = 0; k < 10; k++) nxt();
    @(negedge clk);
    chk("idle_pc_write", 32'(pcw[0]), 1);
    chk("idle_stall_cnt", 32'(sc0), 0);
    // load-use on rs
    nxt();
    ex_mem_read = 1; ex_rt = 8; id_rs = 8;
    @(negedge clk);
    chk("lu_pc_write", 32'(pcw[0]), 0);
    chk("lu_ifid_hold", 32'(hold[0]), 1);
    chk("lu_if_flush", 32'(flu[0]), 0);
    chk("lu_bubble", 32'(bub[0]), 1);
    chk("lu_cnt_before", 32'(sc0), 0);
    nxt();
    clr();
    @(negedge clk);
    chk("lu_cnt_after", 32'(sc0), 1);
    // ex_rt = 0 never stalls
    nxt();
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    @(negedge clk);
    chk("lu_r0_pc_write", 32'(pcw[0]), 1);
    // rt match without rt use
    nxt();
    ex_mem_read = 1; ex_rt = 9; id_rt = 9; id_rs = 1;
    @(negedge clk);
    chk("lu_nort_pc_write", 32'(pcw[0]), 1);
    nxt();
    id_uses_rt = 1;
    @(negedge clk);
    chk("lu_rt_pc_write", 32'(pcw[0]), 0);
    // redirect alone
    nxt();
    clr();
    id_redirect = 1;
    @(negedge clk);
    chk("rd_pc_write", 32'(pcw[0]), 1);
    chk("rd_pc_sel", 32'(psel[0]), 1);
    chk("rd_if_flush", 32'(flu[0]), 1);
    // redirect with load-use: stall wins
    nxt();
    ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    @(negedge clk);
    chk("rdlu_flush_cnt", 32'(fc0), 1);
    chk("rdlu_pc_sel", 32'(psel[0]), 0);
    chk("rdlu_if_flush", 32'(flu[0]), 0);
    nxt();
    ex_mem_read = 0;
    @(negedge clk);
    chk("rdlu_flush_hold", 32'(fc0), 1);
    chk("rdlu_pc_sel_next", 32'(psel[0]), 1);
    chk("rdlu_stall_cnt", 32'(sc0), 3);
    nxt();
    clr();
    @(negedge clk);
    chk("rdlu_flush_after", 32'(fc0), 2);
    // md interlock
    do_reset();
    id_md_op = 1;
    for (int k = 1; k <= 9; k++) begin
      nxt();
      id_md_op = 0;
      id_hilo_read = 1;
      @(negedge clk);
      if (k <= 4) begin
        chk("md_busy4", 32'(busy[0]), 1);
        chk("md_stall4", 32'(pcw[0]), 0);
      end else if (k == 5) begin
        chk("md_go4", 32'(pcw[0]), 1);
        chk("md_cnt4", 32'(sc0), 4);
      end
      if (k == 9) begin
        chk("md_go8", 32'(pcw[1]), 1);
        chk("md_cnt8", 32'(sc1), 8);
      end
    end
    // reset in 3rd busy cycle
    do_reset();
    id_md_op = 1;
    nxt();
    id_md_op = 0;
    id_hilo_read = 1;
    nxt();
    nxt();
    rst = 1;
    @(negedge clk);
    chk("mrst_busy", 32'(busy[1]), 1);
    chk("mrst_hold", 32'(hold[1]), 1);
    chk("mrst_flush", 32'(flu[1]), 1);
    chk("mrst_pc_write", 32'(pcw[1]), 0);
    nxt();
    rst = 0;
    @(negedge clk);
    chk("mrst_busy_after", 32'(busy[1]), 0);
    chk("mrst_stall_cnt", 32'(sc1), 0);
    chk("mrst_flush_cnt", 32'(fc1), 0);
    chk("mrst_pc_write_after", 32'(pcw[1]), 1);
    // saturation
    do_reset();
    ex_mem_read = 1; ex_rt = 3; id_rs = 3;
    for (int k = 1; k < 20; k++) nxt();
    nxt();
    clr();
    @(negedge clk);
    chk("sat_cnt4", 32'(sc0), 15);
    chk("sat_cnt16", 32'(sc1), 20);
    nxt();
    @(negedge clk);
    chk("sat_hold", 32'(sc0), 15);
    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
